// File: rtl/cu_fsm_multi.sv
// Multi-cycle sequencing controller for the OTTER core: steps each instruction
// through fetch and decode, plus optional memory, mul/div and trap entry states.
module cu_fsm_multi #(
  parameter bit EN_MULDIV = 1'b1,
  parameter bit EN_INTR   = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             mem_ready,
  input  logic             md_done,
  input  logic             intr,
  input  logic             mie,
  output logic             mem_rden1,
  output logic             mem_rden2,
  output logic             mem_we2,
  output logic             ir_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             md_start,
  output logic             int_taken,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);
  // state  | meaning
  // FETCH  | instruction read in flight, IR loads on mem_ready
  // DECODE | classify IR, retire single-cycle ops, sample interrupt
  // MEM    | data read or write held until mem_ready
  // MULDIV | waiting for md_done from the mul/div unit
  // TRAP   | one-cycle trap entry, then refetch from mtvec
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_MULDIV = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t           state, state_nxt;
  logic             mem_wr, mem_wr_nxt;
  logic [CNT_W-1:0] cnt;
  logic             legal, is_md, retire;
  logic             rden1, rden2, we2, irw, rfw, pcw, mds, trap, ill;
  logic             unused_func3;

  // func3 plays no part in sequencing; the datapath decoder owns it.
  assign unused_func3 = ^func3;

  always_comb begin
    legal = 1'b0;
    is_md = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_SYSTEM: legal = 1'b1;
      OP_REG: begin
        if (func7 == 7'b0000000 || func7 == 7'b0100000) begin
          legal = 1'b1;
        end else if (EN_MULDIV && func7 == 7'b0000001) begin
          legal = 1'b1;
          is_md = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_FETCH;
      mem_wr <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      mem_wr <= mem_wr_nxt;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_wr_nxt = mem_wr;
    rden1  = 1'b0;
    rden2  = 1'b0;
    we2    = 1'b0;
    irw    = 1'b0;
    rfw    = 1'b0;
    pcw    = 1'b0;
    mds    = 1'b0;
    trap   = 1'b0;
    ill    = 1'b0;
    retire = 1'b0;
    case (state)
      ST_FETCH: begin
        rden1 = 1'b1;
        if (mem_ready) begin
          irw       = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (EN_INTR && intr && mie) begin
          state_nxt = ST_TRAP;
        end else if (!legal) begin
          ill = 1'b1;
          // Without trap support the bad word is skipped and not counted.
          if (EN_INTR) begin
            state_nxt = ST_TRAP;
          end else begin
            pcw       = 1'b1;
            state_nxt = ST_FETCH;
          end
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          mem_wr_nxt = (opcode == OP_STORE);
          state_nxt  = ST_MEM;
        end else if (is_md) begin
          mds       = 1'b1;
          state_nxt = ST_MULDIV;
        end else if (opcode == OP_BRANCH) begin
          pcw       = 1'b1;
          retire    = 1'b1;
          state_nxt = ST_FETCH;
        end else begin
          rfw       = 1'b1;
          pcw       = 1'b1;
          retire    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_MEM: begin
        rden2 = !mem_wr;
        we2   = mem_wr;
        if (mem_ready) begin
          rfw       = !mem_wr;
          pcw       = 1'b1;
          retire    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_MULDIV: begin
        if (md_done) begin
          rfw       = 1'b1;
          pcw       = 1'b1;
          retire    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_TRAP: begin
        trap      = 1'b1;
        pcw       = 1'b1;
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held, since FETCH would otherwise
  // present a fetch request during reset.
  assign mem_rden1     = rden1 & ~rst;
  assign mem_rden2     = rden2 & ~rst;
  assign mem_we2       = we2   & ~rst;
  assign ir_we         = irw   & ~rst;
  assign rf_we         = rfw   & ~rst;
  assign pc_we         = pcw   & ~rst;
  assign md_start      = mds   & ~rst;
  assign int_taken     = trap  & ~rst;
  assign illegal_instr = ill   & ~rst;
  assign instret       = cnt;
  assign state_o       = state;
endmodule

// File: tb/tb_cu_fsm_multi.sv
// Bench for cu_fsm_multi: directed scenarios on three parameterisations plus a
// randomized instruction stream checked against an instruction-level model.
module tb_cu_fsm_multi;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // bit order: rden1 rden2 we2 ir_we rf_we pc_we md_start int_taken illegal
  localparam logic [8:0] V_NONE     = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_FETCH    = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_FETCH_OK = 9'b1_0_0_1_0_0_0_0_0;
  localparam logic [8:0] V_RETIRE   = 9'b0_0_0_0_1_1_0_0_0;
  localparam logic [8:0] V_PC       = 9'b0_0_0_0_0_1_0_0_0;
  localparam logic [8:0] V_RD       = 9'b0_1_0_0_0_0_0_0_0;
  localparam logic [8:0] V_RD_OK    = 9'b0_1_0_0_1_1_0_0_0;
  localparam logic [8:0] V_WR       = 9'b0_0_1_0_0_0_0_0_0;
  localparam logic [8:0] V_WR_OK    = 9'b0_0_1_0_0_1_0_0_0;
  localparam logic [8:0] V_MDS      = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] V_TRAP     = 9'b0_0_0_0_0_1_0_1_0;
  localparam logic [8:0] V_ILL      = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] V_ILL_SKIP = 9'b0_0_0_0_0_1_0_0_1;

  localparam int C_ALU = 0, C_BR = 1, C_LD = 2, C_ST = 3, C_MD = 4,
                 C_ILL = 5, C_INT = 6, C_SKIP = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = '0, func7 = '0;
  logic [2:0] func3 = '0;
  logic mem_ready = 1'b0, md_done = 1'b0, intr = 1'b0, mie = 1'b0;

  wire [8:0]  va, vb, vc;
  wire [2:0]  st_a, st_b, st_c;
  wire [31:0] ic_a, ic_c;
  wire [3:0]  ic_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cu_fsm_multi dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .mem_ready(mem_ready), .md_done(md_done), .intr(intr), .mie(mie),
    .mem_rden1(va[8]), .mem_rden2(va[7]), .mem_we2(va[6]), .ir_we(va[5]),
    .rf_we(va[4]), .pc_we(va[3]), .md_start(va[2]), .int_taken(va[1]),
    .illegal_instr(va[0]), .instret(ic_a), .state_o(st_a));

  cu_fsm_multi #(.EN_MULDIV(1'b0), .EN_INTR(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .mem_ready(mem_ready), .md_done(md_done), .intr(intr), .mie(mie),
    .mem_rden1(vb[8]), .mem_rden2(vb[7]), .mem_we2(vb[6]), .ir_we(vb[5]),
    .rf_we(vb[4]), .pc_we(vb[3]), .md_start(vb[2]), .int_taken(vb[1]),
    .illegal_instr(vb[0]), .instret(ic_b), .state_o(st_b));

  cu_fsm_multi #(.EN_MULDIV(1'b1), .EN_INTR(1'b0), .CNT_W(32)) dut_c (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .mem_ready(mem_ready), .md_done(md_done), .intr(intr), .mie(mie),
    .mem_rden1(vc[8]), .mem_rden2(vc[7]), .mem_we2(vc[6]), .ir_we(vc[5]),
    .rf_we(vc[4]), .pc_we(vc[3]), .md_start(vc[2]), .int_taken(vc[1]),
    .illegal_instr(vc[0]), .instret(ic_c), .state_o(st_c));

  // Instruction-level reference: what one instruction does, from its encoding.
  function automatic int classify(input logic [6:0] op, input logic [6:0] f7,
                                  input bit en_md, input bit en_int,
                                  input logic irq, input logic ie);
    bit ok;
    if (en_int && irq && ie) return C_INT;
    ok = (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                     OP_STORE, OP_IMM, OP_SYSTEM}) ||
         (op == OP_REG && (f7 == 7'h00 || f7 == 7'h20 || (en_md && f7 == 7'h01)));
    if (!ok) return en_int ? C_ILL : C_SKIP;
    if (op == OP_LOAD) return C_LD;
    if (op == OP_STORE) return C_ST;
    if (op == OP_REG && f7 == 7'h01) return C_MD;
    if (op == OP_BRANCH) return C_BR;
    return C_ALU;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    opcode = OP_IMM; func7 = '0; func3 = '0;
    mem_ready = 1'b0; md_done = 1'b0; intr = 1'b0; mie = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; intr = 1'b1; mie = 1'b1; md_done = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (va !== V_NONE) $display("FAIL rst_strobes_a: got %b want %b", va, V_NONE); else n_pass++;
    n_chk++; if ({vb, vc} !== 18'd0) $display("FAIL rst_strobes_bc: got %b want 0", {vb, vc}); else n_pass++;
    n_chk++; if ({st_a, st_b, st_c} !== 9'd0) $display("FAIL rst_state: got %b want 0", {st_a, st_b, st_c}); else n_pass++;
    n_chk++; if ({ic_a, ic_b, ic_c} !== 68'd0) $display("FAIL rst_instret: got %h want 0", {ic_a, ic_b, ic_c}); else n_pass++;
    @(negedge clk);
    rst = 1'b0; intr = 1'b0; md_done = 1'b0; #1;
    n_chk++; if (va !== V_FETCH_OK) $display("FAIL rst_release_fetch: got %b want %b", va, V_FETCH_OK); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_addi();
    do_reset();
    opcode = OP_IMM; func7 = 7'h55; mem_ready = 1'b1; #1;
    n_chk++; if (va !== V_FETCH_OK) $display("FAIL addi_fetch: got %b want %b", va, V_FETCH_OK); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (va !== V_RETIRE) $display("FAIL addi_exec: got %b want %b", va, V_RETIRE); else n_pass++;
    n_chk++; if (st_a !== 3'd1) $display("FAIL addi_decode_state: got %0d want 1", st_a); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (st_a !== 3'd0) $display("FAIL addi_state_back: got %0d want 0", st_a); else n_pass++;
    n_chk++; if (ic_a !== 32'd1) $display("FAIL addi_instret: got %0d want 1", ic_a); else n_pass++;
  endtask

  task automatic test_lw_wait();
    do_reset();
    opcode = OP_LOAD; mem_ready = 1'b1; #1;
    n_chk++; if (va !== V_FETCH_OK) $display("FAIL lw_fetch: got %b want %b", va, V_FETCH_OK); else n_pass++;
    @(negedge clk); mem_ready = 1'b0; #1;
    n_chk++; if (va !== V_NONE) $display("FAIL lw_decode: got %b want %b", va, V_NONE); else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      n_chk++; if (va !== ((i == 3) ? V_RD_OK : V_RD)) $display("FAIL lw_mem%0d: got %b want %b", i, va, (i == 3) ? V_RD_OK : V_RD); else n_pass++;
      n_chk++; if (st_a !== 3'd2) $display("FAIL lw_mem_state%0d: got %0d want 2", i, st_a); else n_pass++;
      @(negedge clk);
    end
    #1;
    n_chk++; if (st_a !== 3'd0 || ic_a !== 32'd1) $display("FAIL lw_done: got state %0d instret %0d want 0 1", st_a, ic_a); else n_pass++;
  endtask

  task automatic test_mul();
    int starts;
    starts = 0;
    do_reset();
    opcode = OP_REG; func7 = 7'b0000001; mem_ready = 1'b1; #1;
    n_chk++; if (va !== V_FETCH_OK) $display("FAIL mul_fetch: got %b want %b", va, V_FETCH_OK); else n_pass++;
    @(negedge clk); md_done = 1'b1; #1;
    n_chk++; if (va !== V_MDS) $display("FAIL mul_decode: got %b want %b", va, V_MDS); else n_pass++;
    n_chk++; if (vb !== V_ILL) $display("FAIL nomd_decode: got %b want %b", vb, V_ILL); else n_pass++;
    starts += int'(va[2]);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      md_done = (i == 4); mem_ready = 1'b0; #1;
      n_chk++; if (va !== ((i == 4) ? V_RETIRE : V_NONE)) $display("FAIL mul_wait%0d: got %b want %b", i, va, (i == 4) ? V_RETIRE : V_NONE); else n_pass++;
      n_chk++; if (st_a !== 3'd3) $display("FAIL mul_state%0d: got %0d want 3", i, st_a); else n_pass++;
      if (i == 0) begin
        n_chk++; if (vb !== V_TRAP || st_b !== 3'd4) $display("FAIL nomd_trap: got %b state %0d want %b state 4", vb, st_b, V_TRAP); else n_pass++;
      end
      starts += int'(va[2]);
      @(negedge clk);
    end
    md_done = 1'b0; #1;
    n_chk++; if (starts !== 1) $display("FAIL mul_start_count: got %0d want 1", starts); else n_pass++;
    n_chk++; if (ic_a !== 32'd1 || st_a !== 3'd0) $display("FAIL mul_done: got instret %0d state %0d want 1 0", ic_a, st_a); else n_pass++;
    n_chk++; if (ic_b !== 4'd0) $display("FAIL nomd_instret: got %0d want 0", ic_b); else n_pass++;
  endtask

  task automatic test_intr();
    do_reset();
    opcode = OP_STORE; mem_ready = 1'b1; intr = 1'b1; mie = 1'b1; #1;
    n_chk++; if (va !== V_FETCH_OK) $display("FAIL intr_fetch: got %b want %b", va, V_FETCH_OK); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (va !== V_NONE) $display("FAIL intr_decode: got %b want %b", va, V_NONE); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (va !== V_TRAP || st_a !== 3'd4) $display("FAIL intr_trap: got %b state %0d want %b state 4", va, st_a, V_TRAP); else n_pass++;
    @(negedge clk); mie = 1'b0; #1;
    n_chk++; if (ic_a !== 32'd0 || va !== V_FETCH_OK) $display("FAIL intr_after: got instret %0d strobes %b want 0 %b", ic_a, va, V_FETCH_OK); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (va !== V_NONE || st_a !== 3'd1) $display("FAIL sw_decode: got %b state %0d want %b state 1", va, st_a, V_NONE); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (va !== V_WR_OK || st_a !== 3'd2) $display("FAIL sw_mem: got %b state %0d want %b state 2", va, st_a, V_WR_OK); else n_pass++;
    @(negedge clk); intr = 1'b0; #1;
    n_chk++; if (ic_a !== 32'd1) $display("FAIL sw_instret: got %0d want 1", ic_a); else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'b0000000; mem_ready = 1'b1; #1;
    n_chk++; if (vc !== V_FETCH_OK) $display("FAIL ill_fetch: got %b want %b", vc, V_FETCH_OK); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (vc !== V_ILL_SKIP) $display("FAIL ill_skip: got %b want %b", vc, V_ILL_SKIP); else n_pass++;
    n_chk++; if (va !== V_ILL) $display("FAIL ill_trapmode: got %b want %b", va, V_ILL); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (st_c !== 3'd0 || ic_c !== 32'd0) $display("FAIL ill_after: got state %0d instret %0d want 0 0", st_c, ic_c); else n_pass++;
    n_chk++; if (st_a !== 3'd4) $display("FAIL ill_trap_state: got %0d want 4", st_a); else n_pass++;
  endtask

  task automatic test_wrap();
    int model;
    model = 0;
    do_reset();
    opcode = OP_IMM; mem_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); @(negedge clk);
      model = (model + 1) % 16;
      if (i == 15) begin
        #1;
        n_chk++; if (ic_b !== 4'(model)) $display("FAIL wrap16: got %0d want %0d", ic_b, model); else n_pass++;
      end
    end
    #1;
    n_chk++; if (ic_b !== 4'(model)) $display("FAIL wrap17: got %0d want %0d", ic_b, model); else n_pass++;
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = OP_LOAD; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (va !== V_RD || st_a !== 3'd2) $display("FAIL midrst_pre: got %b state %0d want %b state 2", va, st_a, V_RD); else n_pass++;
    #1 mem_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_chk++; if (va !== V_NONE || st_a !== 3'd0) $display("FAIL midrst_abort: got %b state %0d want 0 state 0", va, st_a); else n_pass++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    n_chk++; if (st_a !== 3'd0 || va !== V_FETCH_OK || ic_a !== 32'd0) $display("FAIL midrst_release: got %b state %0d instret %0d", va, st_a, ic_a); else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] pool [10];
    logic [6:0] op, f7;
    logic       irq, ie;
    int         cls, w0, w1, k;
    int unsigned cnt;
    logic [8:0] exp;
    pool = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
             OP_IMM, OP_REG, OP_SYSTEM};
    cnt = 0;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pool[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      irq = ($urandom_range(0, 3) == 0);
      ie  = 1'($urandom_range(0, 1));
      w0  = $urandom_range(0, 2);
      w1  = $urandom_range(0, 3);
      k   = $urandom_range(0, 4);
      cls = classify(op, f7, 1'b1, 1'b1, irq, ie);
      opcode = op; func7 = f7; func3 = 3'($urandom);
      for (int w = 0; w <= w0; w++) begin
        mem_ready = (w == w0); md_done = 1'($urandom_range(0, 1));
        intr = 1'($urandom_range(0, 1)); mie = 1'($urandom_range(0, 1)); #1;
        exp = (w == w0) ? V_FETCH_OK : V_FETCH;
        n_chk++; if (va !== exp || st_a !== 3'd0) $display("FAIL rnd_fetch n%0d: got %b state %0d want %b state 0", n, va, st_a, exp); else n_pass++;
        if (w == 0) begin
          n_chk++; if (ic_a !== cnt) $display("FAIL rnd_instret n%0d: got %0d want %0d", n, ic_a, cnt); else n_pass++;
        end
        @(negedge clk);
      end
      intr = irq; mie = ie;
      mem_ready = 1'($urandom_range(0, 1)); md_done = 1'($urandom_range(0, 1)); #1;
      case (cls)
        C_ALU:   exp = V_RETIRE;
        C_BR:    exp = V_PC;
        C_MD:    exp = V_MDS;
        C_ILL:   exp = V_ILL;
        default: exp = V_NONE;
      endcase
      n_chk++; if (va !== exp || st_a !== 3'd1) $display("FAIL rnd_decode n%0d op %b f7 %b: got %b state %0d want %b", n, op, f7, va, st_a, exp); else n_pass++;
      @(negedge clk);
      if (cls == C_LD || cls == C_ST) begin
        for (int w = 0; w <= w1; w++) begin
          mem_ready = (w == w1); md_done = 1'($urandom_range(0, 1));
          intr = 1'($urandom_range(0, 1)); #1;
          if (cls == C_LD) exp = (w == w1) ? V_RD_OK : V_RD;
          else             exp = (w == w1) ? V_WR_OK : V_WR;
          n_chk++; if (va !== exp || st_a !== 3'd2) $display("FAIL rnd_mem n%0d: got %b state %0d want %b state 2", n, va, st_a, exp); else n_pass++;
          @(negedge clk);
        end
      end else if (cls == C_MD) begin
        for (int w = 0; w <= k; w++) begin
          md_done = (w == k); mem_ready = 1'($urandom_range(0, 1)); #1;
          exp = (w == k) ? V_RETIRE : V_NONE;
          n_chk++; if (va !== exp || st_a !== 3'd3) $display("FAIL rnd_md n%0d: got %b state %0d want %b state 3", n, va, st_a, exp); else n_pass++;
          @(negedge clk);
        end
      end else if (cls == C_ILL || cls == C_INT) begin
        intr = 1'($urandom_range(0, 1)); #1;
        n_chk++; if (va !== V_TRAP || st_a !== 3'd4) $display("FAIL rnd_trap n%0d: got %b state %0d want %b state 4", n, va, st_a, V_TRAP); else n_pass++;
        @(negedge clk);
      end
      if (cls inside {C_ALU, C_BR, C_LD, C_ST, C_MD}) cnt++;
    end
    #1;
    n_chk++; if (ic_a !== cnt) $display("FAIL rnd_final_instret: got %0d want %0d", ic_a, cnt); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_mul();
    test_intr();
    test_illegal();
    test_wrap();
    test_reset_mid_mem();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
